vec_lane_bram: RTL and testbench

- Parametrised successor to the single-port 128-bit vector BRAM: a simple dual-port (one write, one read) memory that stores LANES x LANE_WIDTH vector words.
- Adds per-lane write masking, write-first read/write collision forwarding, a read-valid strobe, and a hardware clear sequencer that zero-fills the array.
- Sits between the SIMD load/store unit and the vector register file as operand/result storage.

---
 rtl/simd_mem_pkg.sv | 16 +
 rtl/vec_lane_bank.sv | 31 +++
 rtl/vec_lane_bram.sv | 133 +++++++++++++
 tb/tb_vec_lane_bram.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/simd_mem_pkg.sv
// Shared types for the SIMD operand/result memories.
// Lane/word defaults and the clear sequencer state encoding.
package simd_mem_pkg;

  localparam int LANES_DEF      = 4;
  localparam int LANE_WIDTH_DEF = 32;

  typedef logic [LANE_WIDTH_DEF-1:0] lane_t;
  typedef lane_t [LANES_DEF-1:0]     vec_t;

  typedef enum logic {
    CLR_IDLE,
    CLR_RUN
  } clr_state_e;

endpackage

// File: rtl/vec_lane_bank.sv
// One lane of vector storage: LANE_WIDTH x DEPTH,
// single write port, registered synchronous read.
module vec_lane_bank #(
  parameter  int W     = 32,
  parameter  int DEPTH = 256,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [DEPTH];

  // array write, contents are never reset
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // read register, holds between accepted reads
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/vec_lane_bram.sv
// Lane-masked dual-port vector memory with clear sequencer.
// Optional macro VEC_LANE_BRAM_OUTREG_EN adds an output stage.
module vec_lane_bram
  import simd_mem_pkg::*;
#(
  parameter  int LANES      = LANES_DEF,
  parameter  int LANE_WIDTH = LANE_WIDTH_DEF,
  parameter  int DEPTH      = 256,
  localparam int AW         = $clog2(DEPTH),
  localparam int DW         = LANES * LANE_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  output logic             busy,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [LANES-1:0] wr_mask,
  input  logic [DW-1:0]    wr_data,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  output logic [DW-1:0]    rd_data,
  output logic             rd_valid
);

  clr_state_e       state;
  logic [AW-1:0]    clr_ptr;
  logic             run;
  logic             wr_ok;
  logic             rd_ok;
  logic             hit;
  logic [LANES-1:0] bank_we;
  logic [AW-1:0]    bank_wa;
  logic [LANES-1:0] fwd_sel;
  logic [DW-1:0]    fwd_data;
  logic [DW-1:0]    s1_data;
  logic             s1_valid;

  assign run   = (state == CLR_RUN);
  assign wr_ok = !run && wr_en && !clear;
  assign rd_ok = !run && rd_en;
  assign hit   = wr_ok && rd_ok
              && (rd_addr == wr_addr);

  assign bank_wa = run ? clr_ptr : wr_addr;

  // clear sequencer: one zero word per cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= CLR_IDLE;
      clr_ptr <= '0;
      busy    <= 1'b0;
    end else begin
      unique case (state)
        CLR_IDLE: begin
          if (clear) begin
            state <= CLR_RUN;
            busy  <= 1'b1;
          end
        end
        CLR_RUN: begin
          clr_ptr <= clr_ptr + AW'(1);
          if (clr_ptr == AW'(DEPTH - 1)) begin
            state <= CLR_IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= CLR_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // capture write-first lane selects at read accept
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fwd_sel  <= '0;
      fwd_data <= '0;
      s1_valid <= 1'b0;
    end else begin
      s1_valid <= rd_ok;
      if (rd_ok) begin
        fwd_sel  <= hit ? wr_mask : '0;
        fwd_data <= wr_data;
      end
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [LANE_WIDTH-1:0] q;
    logic [LANE_WIDTH-1:0] wd;

    assign bank_we[i] = run || (wr_ok && wr_mask[i]);
    assign wd = run ? '0
              : wr_data[i*LANE_WIDTH +: LANE_WIDTH];

    vec_lane_bank #(
      .W     (LANE_WIDTH),
      .DEPTH (DEPTH)
    ) u_bank (
      .clk   (clk),
      .rst_n (rst_n),
      .we    (bank_we[i]),
      .waddr (bank_wa),
      .wdata (wd),
      .re    (rd_ok),
      .raddr (rd_addr),
      .rdata (q)
    );

    assign s1_data[i*LANE_WIDTH +: LANE_WIDTH] =
      fwd_sel[i] ? fwd_data[i*LANE_WIDTH +: LANE_WIDTH] : q;
  end

`ifdef VEC_LANE_BRAM_OUTREG_EN
  // second output stage, runs even while clearing
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= s1_valid;
      if (s1_valid) rd_data <= s1_data;
    end
  end
`else
  assign rd_data  = s1_data;
  assign rd_valid = s1_valid;
`endif

endmodule

// File: tb/tb_vec_lane_bram.sv
// Scoreboard bench for vec_lane_bram.
// Honours VEC_LANE_BRAM_OUTREG_EN for read latency.
module tb_vec_lane_bram;

`ifdef VEC_LANE_BRAM_OUTREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  typedef struct {
    logic [127:0] data;
    int           due;
  } exp_t;

  logic         clk = 0;
  logic         rst_n = 0;
  logic         clear = 0;
  logic         busy;
  logic         wr_en = 0;
  logic [7:0]   wr_addr = 0;
  logic [3:0]   wr_mask = 0;
  logic [127:0] wr_data = 0;
  logic         rd_en = 0;
  logic [7:0]   rd_addr = 0;
  logic [127:0] rd_data;
  logic         rd_valid;

  logic [127:0] model [256];
  exp_t         sb [$];
  int           cyc = 0;
  int           asserts = 0;
  int           fails = 0;
  logic [127:0] last_exp = '0;

  vec_lane_bram dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (clear),
    .busy     (busy),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_mask  (wr_mask),
    .wr_data  (wr_data),
    .rd_en    (rd_en),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .rd_valid (rd_valid)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    asserts++;
    if (sb.size() > 0 && sb[0].due < cyc) begin
      fails++;
      $display("FAIL rd_late: due %0d now %0d",
               sb[0].due, cyc);
      void'(sb.pop_front());
    end else if (sb.size() > 0 && sb[0].due == cyc) begin
      if (rd_valid !== 1'b1 || rd_data !== sb[0].data) begin
        fails++;
        $display("FAIL rd_data: got v=%b %h want v=1 %h",
                 rd_valid, rd_data, sb[0].data);
      end
      last_exp = sb[0].data;
      void'(sb.pop_front());
    end else if (rd_valid !== 1'b0) begin
      fails++;
      $display("FAIL rd_valid_spurious: got %b want 0",
               rd_valid);
    end
  end

  // one idle-state cycle; computes expectation before the edge
  task automatic step(input logic we, input logic [7:0] wa,
                      input logic [3:0] wm,
                      input logic [127:0] wd,
                      input logic re, input logic [7:0] ra);
    exp_t e;
    wr_en = we; wr_addr = wa; wr_mask = wm; wr_data = wd;
    rd_en = re; rd_addr = ra;
    if (re) begin
      e.data = model[ra];
      if (we && wa == ra)
        for (int l = 0; l < 4; l++)
          if (wm[l]) e.data[l*32 +: 32] = wd[l*32 +: 32];
      e.due = cyc + LAT;
      sb.push_back(e);
    end
    if (we)
      for (int l = 0; l < 4; l++)
        if (wm[l]) model[wa][l*32 +: 32] = wd[l*32 +: 32];
    @(posedge clk); #1;
    wr_en = 0; rd_en = 0;
  endtask

  task automatic drain();
    for (int i = 0; i < 10 && sb.size() > 0; i++) begin
      @(posedge clk); #1;
    end
    asserts++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d reads pending want 0",
               sb.size());
      sb.delete();
    end
  endtask

  task automatic test_reset();
    #1;
    asserts++;
    if (busy !== 1'b0 || rd_valid !== 1'b0 ||
        rd_data !== 128'h0) begin
      fails++;
      $display("FAIL reset: busy=%b v=%b d=%h want 0 0 0",
               busy, rd_valid, rd_data);
    end
    @(posedge clk); #1;
    rst_n = 1;
    @(posedge clk); #1;
  endtask

  task automatic test_write_read();
    step(1, 8'd5, 4'hF,
         128'h00000004_00000003_00000002_00000001, 0, 0);
    step(0, 0, 0, 0, 1, 8'd5);
    drain();
    repeat (3) begin
      @(posedge clk); #1;
    end
    asserts++;
    if (rd_data !== 128'h00000004_00000003_00000002_00000001) begin
      fails++;
      $display("FAIL rd_hold: got %h want %h",
               rd_data, 128'h00000004_00000003_00000002_00000001);
    end
  endtask

  task automatic test_mask();
    step(1, 8'd5, 4'b0101, {4{32'hAAAAAAAA}}, 0, 0);
    step(0, 0, 0, 0, 1, 8'd5);
    drain();
    asserts++;
    if (last_exp !== 128'h00000004_AAAAAAAA_00000002_AAAAAAAA) begin
      fails++;
      $display("FAIL mask_model: got %h want %h", last_exp,
               128'h00000004_AAAAAAAA_00000002_AAAAAAAA);
    end
    step(1, 8'd5, 4'b0000, {4{32'h55555555}}, 0, 0);
    step(0, 0, 0, 0, 1, 8'd5);
    drain();
  endtask

  task automatic test_collision();
    step(1, 8'd7, 4'hF, {4{32'h11}}, 0, 0);
    step(1, 8'd7, 4'b0011, {4{32'hFF}}, 1, 8'd7);
    drain();
    asserts++;
    if (last_exp !== 128'h00000011_00000011_000000FF_000000FF) begin
      fails++;
      $display("FAIL collide_model: got %h want %h", last_exp,
               128'h00000011_00000011_000000FF_000000FF);
    end
    step(0, 0, 0, 0, 1, 8'd7);
    drain();
  endtask

  task automatic test_back_to_back();
    for (int a = 0; a < 4; a++)
      step(1, 8'(a), 4'hF, {4{32'(a * 16 + 3)}}, 0, 0);
    for (int a = 0; a < 4; a++)
      step(0, 0, 0, 0, 1, 8'(a));
    drain();
  endtask

  task automatic test_clear();
    int n;
    clear = 1;
    wr_en = 1; wr_addr = 8'd9; wr_mask = 4'hF;
    wr_data = {4{32'hDEAD}};
    @(posedge clk); #1;
    clear = 0;
    n = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (!busy) break;
      n++;
      clear = (n == 100);
      wr_en = 1; wr_addr = 8'(n); wr_mask = 4'hF;
      wr_data = {4{32'hBEEF}};
      rd_en = 1; rd_addr = 8'(n);
    end
    wr_en = 0; rd_en = 0; clear = 0;
    asserts++;
    if (n != 256) begin
      fails++;
      $display("FAIL busy_len: got %0d want 256", n);
    end
    for (int a = 0; a < 256; a++) model[a] = '0;
    @(posedge clk); #1;
    for (int a = 0; a < 256; a++)
      step(0, 0, 0, 0, 1, 8'(a));
    drain();
  endtask

  task automatic test_reset_mid_clear();
    for (int a = 0; a < 11; a++)
      step(1, 8'(a), 4'hF, {4{32'(a + 32'h100)}}, 0, 0);
    step(1, 8'd200, 4'hF, {4{32'hC0FFEE}}, 0, 0);
    clear = 1;
    @(posedge clk); #1;
    clear = 0;
    repeat (10) begin
      @(posedge clk); #1;
    end
    rst_n = 0;
    #1;
    asserts++;
    if (busy !== 1'b0 || rd_valid !== 1'b0) begin
      fails++;
      $display("FAIL rst_mid: busy=%b v=%b want 0 0",
               busy, rd_valid);
    end
    for (int a = 0; a < 10; a++) model[a] = '0;
    @(posedge clk); #1;
    rst_n = 1;
    @(posedge clk); #1;
    for (int a = 0; a < 11; a++)
      step(0, 0, 0, 0, 1, 8'(a));
    step(0, 0, 0, 0, 1, 8'd200);
    drain();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: sim still running");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_write_read();
    test_mask();
    test_collision();
    test_back_to_back();
    test_clear();
    test_reset_mid_clear();
    repeat (4) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures",
             asserts, fails);
    $finish;
  end

endmodule
